// File: rtl/bakraid_palette.sv
// Palette stage of the video path: 2048-entry xBGR555 RAM with a CPU port
// (DTACK handshake), a post-reset clear sweep and a two-stage dot pipeline.
module bakraid_palette #(
  parameter int          PAL_AW  = 11,
  parameter logic [15:0] CLR_VAL = 16'h0000
) (
  input  logic              CLK96,
  input  logic              RESET96,
  input  logic              PIXEL_CEN,
  input  logic [PAL_AW-1:0] PIXEL_IDX,
  input  logic              ACTIVE,
  input  logic              CPU_CS,
  input  logic              CPU_RNW,
  input  logic [PAL_AW-1:0] CPU_ADDR,
  input  logic [15:0]       CPU_DIN,
  input  logic              CPU_UDS,
  input  logic              CPU_LDS,
  output logic [15:0]       CPU_DOUT,
  output logic              CPU_DTACK,
  output logic              INIT_BUSY,
  output logic [7:0]        RED,
  output logic [7:0]        GREEN,
  output logic [7:0]        BLUE
);

  // CPU handshake: CS is held for the whole bus cycle; DTACK stays high in ACK
  // until CS is seen low, so each access needs CS low for at least one cycle.
  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, ACK} state_t;

  localparam logic [PAL_AW-1:0] CLR_LAST = '1;

  state_t              state;
  logic [PAL_AW-1:0]   clr_addr;
  logic [PAL_AW-1:0]   addr_q;
  logic [15:0]         din_q;
  logic                rnw_q;
  logic                uds_q;
  logic                lds_q;

  logic [15:0]         pal [2**PAL_AW];

  logic [PAL_AW-1:0]   wr_addr;
  logic [15:0]         wr_data;
  logic                wr_hi;
  logic                wr_lo;
  logic [14:0]         vid_word;

  logic [14:0]         s1_word;
  logic                s1_act;

  function automatic logic [7:0] expand(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Single write port shared by the clear sweep and CPU writes.
  always_comb begin
    wr_addr = addr_q;
    wr_data = din_q;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    if (state == CLEAR) begin
      wr_addr = clr_addr;
      wr_data = CLR_VAL;
      wr_hi   = 1'b1;
      wr_lo   = 1'b1;
    end else if (state == ACCESS && !rnw_q) begin
      wr_hi = uds_q;
      wr_lo = lds_q;
    end
  end

  always_ff @(posedge CLK96) begin
    if (wr_hi) pal[wr_addr][15:8] <= wr_data[15:8];
    if (wr_lo) pal[wr_addr][7:0]  <= wr_data[7:0];
  end

  // Video read with write-first bypass so a same-edge write is seen at once.
  always_comb begin
    vid_word = pal[PIXEL_IDX][14:0];
    if (wr_addr == PIXEL_IDX) begin
      if (wr_hi) vid_word[14:8] = wr_data[14:8];
      if (wr_lo) vid_word[7:0]  = wr_data[7:0];
    end
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      rnw_q     <= 1'b1;
      uds_q     <= 1'b0;
      lds_q     <= 1'b0;
      CPU_DOUT  <= '0;
      CPU_DTACK <= 1'b0;
      INIT_BUSY <= 1'b1;
      s1_word   <= '0;
      s1_act    <= 1'b0;
      RED       <= '0;
      GREEN     <= '0;
      BLUE      <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == CLR_LAST) begin
            state     <= IDLE;
            INIT_BUSY <= 1'b0;
          end
        end
        IDLE: begin
          if (CPU_CS) begin
            addr_q <= CPU_ADDR;
            din_q  <= CPU_DIN;
            rnw_q  <= CPU_RNW;
            uds_q  <= CPU_UDS;
            lds_q  <= CPU_LDS;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (rnw_q) CPU_DOUT <= pal[addr_q];
          CPU_DTACK <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          if (!CPU_CS) begin
            CPU_DTACK <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= CLEAR;
      endcase

      if (PIXEL_CEN) begin
        s1_word <= vid_word;
        s1_act  <= ACTIVE;
        if (s1_act && !INIT_BUSY) begin
          RED   <= expand(s1_word[4:0]);
          GREEN <= expand(s1_word[9:5]);
          BLUE  <= expand(s1_word[14:10]);
        end else begin
          RED   <= '0;
          GREEN <= '0;
          BLUE  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bakraid_palette.sv
// Directed plus randomized bench for bakraid_palette: palette RAM model,
// dot-pipeline history queue and CPU handshake timing checks.
module tb_bakraid_palette;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [10:0] idx;
  logic        act;
  logic        cs;
  logic        rnw;
  logic [10:0] addr;
  logic [15:0] din;
  logic        uds;
  logic        lds;
  logic [15:0] dout;
  logic        dtack;
  logic        busy;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] model_ram [2048];
  logic [23:0] exp_q[$];

  bakraid_palette #(.PAL_AW(11), .CLR_VAL(16'h0000)) dut (
    .CLK96(clk), .RESET96(rst), .PIXEL_CEN(cen), .PIXEL_IDX(idx), .ACTIVE(act),
    .CPU_CS(cs), .CPU_RNW(rnw), .CPU_ADDR(addr), .CPU_DIN(din),
    .CPU_UDS(uds), .CPU_LDS(lds), .CPU_DOUT(dout), .CPU_DTACK(dtack),
    .INIT_BUSY(busy), .RED(red), .GREEN(green), .BLUE(blue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 5-bit channel to 8 bits by replicating the top bits into the low bits.
  function automatic logic [23:0] rgb_of(input logic [15:0] w);
    int r, g, b;
    r = int'(w) % 32;
    g = (int'(w) / 32) % 32;
    b = (int'(w) / 1024) % 32;
    return {8'(r * 8 + r / 4), 8'(g * 8 + g / 4), 8'(b * 8 + b / 4)};
  endfunction

  task automatic cpu_access(input logic r, input logic [10:0] a, input logic [15:0] d,
                            input logic u, input logic l,
                            output logic [15:0] rdata, output int lat);
    cen = 1'b0;
    cs = 1'b1; rnw = r; addr = a; din = d; uds = u; lds = l;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!dtack && lat < 20);
    rdata = dout;
    if (!r) begin
      if (u) model_ram[a][15:8] = d[15:8];
      if (l) model_ram[a][7:0]  = d[7:0];
    end
    cs = 1'b0;
    tick();
    check("dtack_drop", {31'd0, dtack}, 32'd0);
  endtask

  task automatic count_clear(output int cnt, output bit saw_rgb, output bit saw_dtack);
    cnt = 0; saw_rgb = 0; saw_dtack = 0;
    while (busy && cnt < 5000) begin
      cen = 1'b1; act = 1'b1; idx = 11'($urandom_range(0, 2047));
      tick();
      cnt++;
      if (busy && ({red, green, blue} != 24'h0)) saw_rgb = 1;
      if (busy && dtack) saw_dtack = 1;
    end
    cen = 1'b0; act = 1'b0;
  endtask

  task automatic video_pulse(input logic [10:0] i, input logic a);
    cen = 1'b1; idx = i; act = a;
    tick();
    cen = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int lat, cnt, k;
    bit saw_rgb, saw_dtack, flag;

    rst = 1'b1; cen = 0; idx = 0; act = 0;
    cs = 0; rnw = 1; addr = 0; din = 0; uds = 0; lds = 0;
    repeat (3) tick();
    check("rst_dtack", {31'd0, dtack}, 32'd0);
    check("rst_dout", {16'd0, dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rgb", {8'd0, red, green, blue}, 32'd0);

    rst = 1'b0;
    count_clear(cnt, saw_rgb, saw_dtack);
    check("clear_len", cnt, 2048);
    check("clear_rgb_zero", {31'd0, saw_rgb}, 32'd0);
    for (int i = 0; i < 2048; i++) model_ram[i] = 16'h0000;

    cpu_access(1'b1, 11'd5, 16'h0, 1'b1, 1'b1, rd, lat);
    check("read5_data", {16'd0, rd}, 32'h0000);
    check("read5_lat", lat, 2);

    cpu_access(1'b0, 11'd3, 16'h7C1F, 1'b1, 1'b1, rd, lat);
    check("write3_lat", lat, 2);
    video_pulse(11'd3, 1'b1);
    video_pulse(11'd0, 1'b0);
    check("magenta_r", {24'd0, red}, 32'hFF);
    check("magenta_g", {24'd0, green}, 32'h00);
    check("magenta_b", {24'd0, blue}, 32'hFF);

    cpu_access(1'b0, 11'd7, 16'h1234, 1'b1, 1'b1, rd, lat);
    cpu_access(1'b0, 11'd7, 16'hAB00, 1'b1, 1'b0, rd, lat);
    cpu_access(1'b1, 11'd7, 16'h0, 1'b1, 1'b1, rd, lat);
    check("byte_merge", {16'd0, rd}, 32'hAB34);
    check("byte_read_lat", lat, 2);
    cpu_access(1'b0, 11'd7, 16'hFFFF, 1'b0, 1'b0, rd, lat);
    check("no_enable_ack_lat", lat, 2);
    check("dout_unchanged_by_write", {16'd0, rd}, 32'hAB34);
    cpu_access(1'b1, 11'd7, 16'h0, 1'b1, 1'b1, rd, lat);
    check("no_enable_data", {16'd0, rd}, 32'hAB34);

    // Same-edge collision: the ACCESS edge is the second edge after CS rises.
    cs = 1; rnw = 0; addr = 11'd10; din = 16'h03E0; uds = 1; lds = 1;
    tick();
    cen = 1; idx = 11'd10; act = 1;
    tick();
    cen = 0; cs = 0;
    check("bypass_dtack", {31'd0, dtack}, 32'd1);
    tick();
    model_ram[10] = 16'h03E0;
    video_pulse(11'd0, 1'b0);
    check("bypass_rgb", {8'd0, red, green, blue}, 32'h00FF00);

    cpu_access(1'b0, 11'd20, 16'h7FFF, 1'b1, 1'b1, rd, lat);
    video_pulse(11'd20, 1'b0);
    video_pulse(11'd20, 1'b1);
    check("inactive_rgb", {8'd0, red, green, blue}, 32'h0);
    video_pulse(11'd0, 1'b0);
    check("white_rgb", {8'd0, red, green, blue}, 32'hFFFFFF);

    cs = 1; rnw = 1; addr = 11'd20;
    k = 0;
    do begin tick(); k++; end while (!dtack && k < 20);
    check("hold_lat", k, 2);
    flag = 1;
    repeat (5) begin tick(); if (!dtack) flag = 0; end
    check("hold_dtack", {31'd0, flag}, 32'd1);
    check("hold_dout", {16'd0, dout}, 32'h7FFF);
    cs = 0;
    tick();
    check("hold_release", {31'd0, dtack}, 32'd0);

    // Random CPU traffic interleaved with random dots over a small window.
    exp_q.delete();
    for (int it = 0; it < 12; it++) begin
      logic [10:0] ra;
      ra = 11'(40 + $urandom_range(0, 7));
      cpu_access(1'b0, ra, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, lat);
      ra = 11'(40 + $urandom_range(0, 7));
      cpu_access(1'b1, ra, 16'h0, 1'b1, 1'b1, rd, lat);
      check("rand_read", {16'd0, rd}, {16'd0, model_ram[ra]});
      for (int c = 0; c < 30; c++) begin
        cen = 1'($urandom_range(0, 1));
        idx = 11'(40 + $urandom_range(0, 7));
        act = 1'($urandom_range(0, 1));
        tick();
        if (cen) begin
          exp_q.push_back(act ? rgb_of(model_ram[idx]) : 24'h0);
          if (exp_q.size() > 2) void'(exp_q.pop_front());
        end
        if (exp_q.size() == 2)
          check("rand_rgb", {8'd0, red, green, blue}, {8'd0, exp_q[0]});
      end
      cen = 0;
    end

    // Reset in the middle of an acknowledged access.
    cs = 1; rnw = 1; addr = 11'd3;
    k = 0;
    do begin tick(); k++; end while (!dtack && k < 20);
    #2 rst = 1'b1;
    #1;
    check("midack_dtack", {31'd0, dtack}, 32'd0);
    check("midack_busy", {31'd0, busy}, 32'd1);
    check("midack_dout", {16'd0, dout}, 32'd0);
    cs = 0;
    tick();
    rst = 1'b0;
    repeat (1000) tick();
    check("partial_clear_busy", {31'd0, busy}, 32'd1);
    check("partial_clear_addr", {21'd0, dut.clr_addr}, 32'd1000);
    rst = 1'b1;
    tick();
    check("reclear_addr", {21'd0, dut.clr_addr}, 32'd0);
    rst = 1'b0;
    cs = 1; rnw = 1; addr = 11'd20;
    count_clear(cnt, saw_rgb, saw_dtack);
    check("reclear_len", cnt, 2048);
    check("reclear_no_dtack", {31'd0, saw_dtack}, 32'd0);
    k = 0;
    while (!dtack && k < 20) begin tick(); k++; end
    check("queued_read_lat", k, 2);
    check("queued_read_data", {16'd0, dout}, 32'h0000);
    cs = 0;
    tick();
    cpu_access(1'b1, 11'd3, 16'h0, 1'b1, 1'b1, rd, lat);
    check("reclear_entry3", {16'd0, rd}, 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
